// File: rtl/pipelined_memory_loader.sv
// Streams a counted burst of words from a valid/ready producer into a word-addressed memory,
// issuing registered writes with one-cycle latency and keeping a running sum of the words.
module pipelined_memory_loader #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter logic [29:0] BASE_INDEX = 30'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DEPTH_LOG2:0]   count,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [29:0]           mem_index,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           sum
);

  localparam int unsigned CntW = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            state_q, state_d;
  logic [29:0]       index_q;
  logic [CntW-1:0]   remaining_q;
  logic [31:0]       sum_q;
  logic              hs;
  logic              accept_start;

  assign hs           = in_valid & in_ready;
  assign accept_start = (state_q == StIdle) & start;
  assign sum          = sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (count == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (hs && (remaining_q == CntW'(1))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StLoad);
    busy     = (state_q == StLoad);
    done     = (state_q == StDone);
  end

  // Write port registers are the outputs themselves, so a reset at the write edge drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we      <= 1'b0;
      mem_index   <= '0;
      mem_wdata   <= '0;
      index_q     <= BASE_INDEX;
      remaining_q <= '0;
      sum_q       <= '0;
    end else begin
      mem_we <= hs;
      if (hs) begin
        mem_index   <= index_q;
        mem_wdata   <= in_data;
        index_q     <= index_q + 30'd1;
        remaining_q <= remaining_q - CntW'(1);
        sum_q       <= sum_q + in_data;
      end
      if (accept_start) begin
        index_q     <= BASE_INDEX;
        remaining_q <= count;
        sum_q       <= '0;
      end
    end
  end

endmodule
